// File: rtl/fpu_pkg.sv
// Shared FP-side definitions: op codes and the iterative-op classifier.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fpu_pkg;

  localparam logic [2:0] FC_ADD  = 3'b000;
  localparam logic [2:0] FC_SUB  = 3'b001;
  localparam logic [2:0] FC_MUL  = 3'b010;
  localparam logic [2:0] FC_DIV  = 3'b011;
  localparam logic [2:0] FC_SQRT = 3'b100;

  // div and sqrt occupy E1 for several cycles; everything else is single-cycle
  function automatic logic is_iter(input logic [2:0] fc);
    return (fc == FC_DIV) || (fc == FC_SQRT);
  endfunction

endpackage

// File: rtl/fp_regfile.sv
// 32x32 FP register file: two read ports, WB and load write ports.
// Latency: reads combinational with same-cycle write bypass; writes land on the next edge.
// Backpressure: none; the load port wins when both ports write one register.
// Ports: i_ra_n/i_rb_n read addresses -> o_ra_d/o_rb_d; i_wb_* WB write; i_ld_* load write.
module fp_regfile (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  i_ra_n,
  input  logic [4:0]  i_rb_n,
  input  logic        i_wb_w,
  input  logic [4:0]  i_wb_n,
  input  logic [31:0] i_wb_d,
  input  logic        i_ld_w,
  input  logic [4:0]  i_ld_n,
  input  logic [31:0] i_ld_d,
  output logic [31:0] o_ra_d,
  output logic [31:0] o_rb_d
);

  logic [31:0] r_fpr [32];

  // Load write issued last so it overrides a WB write to the same register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) r_fpr[i] <= '0;
    end else begin
      if (i_wb_w) r_fpr[i_wb_n] <= i_wb_d;
      if (i_ld_w) r_fpr[i_ld_n] <= i_ld_d;
    end
  end

  // Bypass priority mirrors write priority: load first, then WB
  assign o_ra_d = (i_ld_w && i_ld_n == i_ra_n) ? i_ld_d :
                  (i_wb_w && i_wb_n == i_ra_n) ? i_wb_d : r_fpr[i_ra_n];
  assign o_rb_d = (i_ld_w && i_ld_n == i_rb_n) ? i_ld_d :
                  (i_wb_w && i_wb_n == i_rb_n) ? i_wb_d : r_fpr[i_rb_n];

endmodule

// File: rtl/fpu_pipe.sv
// FP-side end of the IU/FPU interface: register file, E1/E2/E3/WB bookkeeping, div/sqrt stall.
// Latency: ID->E1->E2->E3->WB one edge each; WB data readable via bypass, in fpr one edge later.
// Backpressure: div/sqrt holds E1 for DIV_CYCLES cycles, raising stall so the IU freezes ID.
// Ports: fs/ft/fd/fc/wf decoded ID fields; fwd* operand selects; mmo/wmo/wrn/wwfpr IU load side;
//        res datapath result; e1*/e2*/e3* stage outputs; dfb swc1 data; stall/st iterative control.
module fpu_pipe
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  fs,
  input  logic [4:0]  ft,
  input  logic [4:0]  fd,
  input  logic [2:0]  fc,
  input  logic        wf,
  input  logic        fwdla,
  input  logic        fwdlb,
  input  logic        fwdfa,
  input  logic        fwdfb,
  input  logic [31:0] mmo,
  input  logic [31:0] wmo,
  input  logic [4:0]  wrn,
  input  logic        wwfpr,
  input  logic [31:0] res,
  output logic [31:0] e1a,
  output logic [31:0] e1b,
  output logic [2:0]  e1c,
  output logic [4:0]  e1n,
  output logic [4:0]  e2n,
  output logic [4:0]  e3n,
  output logic        e1w,
  output logic        e2w,
  output logic        e3w,
  output logic [31:0] e3d,
  output logic [31:0] dfb,
  output logic        stall,
  output logic        st
);

  localparam int CW = $clog2(DIV_CYCLES);

  logic [31:0] r_e1a, r_e1b, r_wbd;
  logic [2:0]  r_e1c;
  logic [4:0]  r_e1n, r_e2n, r_e3n, r_wbn;
  logic        r_e1w, r_e2w, r_e3w, r_wbw;
  logic [CW-1:0] r_cnt;
  logic        r_st;

  logic [31:0] w_ra, w_rb, w_a, w_b;
  logic        w_stall;

  fp_regfile u_rf (
    .clk    (clk),
    .clrn   (clrn),
    .i_ra_n (fs),
    .i_rb_n (ft),
    .i_wb_w (r_wbw),
    .i_wb_n (r_wbn),
    .i_wb_d (r_wbd),
    .i_ld_w (wwfpr),
    .i_ld_n (wrn),
    .i_ld_d (wmo),
    .o_ra_d (w_ra),
    .o_rb_d (w_rb)
  );

  // E3 result forwarding outranks MEM load forwarding
  assign w_a = fwdfa ? res : (fwdla ? mmo : w_ra);
  assign w_b = fwdfb ? res : (fwdlb ? mmo : w_rb);

  assign w_stall = (r_cnt != '0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_e1a <= '0; r_e1b <= '0; r_e1c <= '0; r_e1n <= '0; r_e1w <= 1'b0;
      r_e2n <= '0; r_e2w <= 1'b0;
      r_e3n <= '0; r_e3w <= 1'b0;
      r_wbn <= '0; r_wbw <= 1'b0; r_wbd <= '0;
      r_cnt <= '0;
      r_st  <= 1'b0;
    end else begin
      // E3 and WB drain even while E1 is busy iterating
      r_wbn <= r_e3n;
      r_wbw <= r_e3w;
      r_wbd <= res;
      r_e3n <= r_e2n;
      r_e3w <= r_e2w;
      if (w_stall) begin
        r_cnt <= r_cnt - CW'(1);
        r_st  <= 1'b0;
        r_e2n <= '0;
        r_e2w <= 1'b0;
      end else begin
        r_e2n <= r_e1n;
        r_e2w <= r_e1w;
        r_e1a <= w_a;
        r_e1b <= w_b;
        r_e1c <= fc;
        r_e1n <= fd;
        r_e1w <= wf;
        // Counter holds the remaining extra E1 cycles after this first one
        if (wf && is_iter(fc)) begin
          r_cnt <= CW'(DIV_CYCLES - 1);
          r_st  <= 1'b1;
        end else begin
          r_st  <= 1'b0;
        end
      end
    end
  end

  assign e1a   = r_e1a;
  assign e1b   = r_e1b;
  assign e1c   = r_e1c;
  assign e1n   = r_e1n;
  assign e1w   = r_e1w;
  assign e2n   = r_e2n;
  assign e2w   = r_e2w;
  assign e3n   = r_e3n;
  assign e3w   = r_e3w;
  assign e3d   = res;
  assign dfb   = w_rb;
  assign stall = w_stall;
  assign st    = r_st;

endmodule

// File: tb/tb_fpu_pipe.sv
// Self-checking bench for fpu_pipe: directed scenarios plus randomized traffic vs a stage-record model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fpu_pipe;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  fs, ft, fd, wrn;
  logic [2:0]  fc;
  logic        wf, fwdla, fwdlb, fwdfa, fwdfb, wwfpr;
  logic [31:0] mmo, wmo, res;
  logic [31:0] e1a, e1b, e3d, dfb;
  logic [2:0]  e1c;
  logic [4:0]  e1n, e2n, e3n;
  logic        e1w, e2w, e3w, stall, st;

  always #5 clk = ~clk;

  fpu_pipe #(.DIV_CYCLES(DC)) dut (
    .clk(clk), .clrn(clrn), .fs(fs), .ft(ft), .fd(fd), .fc(fc), .wf(wf),
    .fwdla(fwdla), .fwdlb(fwdlb), .fwdfa(fwdfa), .fwdfb(fwdfb),
    .mmo(mmo), .wmo(wmo), .wrn(wrn), .wwfpr(wwfpr), .res(res),
    .e1a(e1a), .e1b(e1b), .e1c(e1c), .e1n(e1n), .e2n(e2n), .e3n(e3n),
    .e1w(e1w), .e2w(e2w), .e3w(e3w), .e3d(e3d), .dfb(dfb), .stall(stall), .st(st)
  );

  // One record per instruction; slots are E1, E2, E3, WB
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [4:0]  n;
    logic        w;
    logic [31:0] d;
  } op_t;

  op_t         m_st [4];
  logic [31:0] m_fpr [32];
  int          m_left;   // E1 cycles the current E1 op still needs, including this one
  logic        m_start;
  int          total = 0;
  int          bad = 0;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_fpr[i] = '0;
    for (int i = 0; i < 4; i++) m_st[i] = '0;
    m_left  = 1;
    m_start = 1'b0;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (wwfpr && wrn == r) return wmo;
    if (m_st[3].w && m_st[3].n == r) return m_st[3].d;
    return m_fpr[r];
  endfunction

  function automatic void model_edge();
    op_t id;
    id   = '0;
    id.a = fwdfa ? res : (fwdla ? mmo : mread(fs));
    id.b = fwdfb ? res : (fwdlb ? mmo : mread(ft));
    id.c = fc;
    id.n = fd;
    id.w = wf;
    if (m_st[3].w) m_fpr[m_st[3].n] = m_st[3].d;
    if (wwfpr) m_fpr[wrn] = wmo;
    m_st[3]   = m_st[2];
    m_st[3].d = res;
    m_st[2]   = m_st[1];
    if (m_left > 1) begin
      m_left--;
      m_st[1] = '0;
      m_start = 1'b0;
    end else begin
      m_st[1] = m_st[0];
      m_st[0] = id;
      m_left  = (wf && (fc == 3'b011 || fc == 3'b100)) ? DC : 1;
      m_start = (m_left > 1);
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    fs = '0; ft = '0; fd = '0; fc = '0; wf = 1'b0;
    fwdla = 1'b0; fwdlb = 1'b0; fwdfa = 1'b0; fwdfb = 1'b0;
    mmo = '0; wmo = '0; wrn = '0; wwfpr = 1'b0; res = '0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    set_idle();
    m_reset();
    #12;
    total++;
    if ({e1a, e1b, e1c, e1n, e1w} !== '0) begin
      bad++; $display("FAIL reset_e1 act=%h exp=0", {e1a, e1b, e1c, e1n, e1w});
    end
    total++;
    if ({e2n, e2w, e3n, e3w, stall, st} !== '0) begin
      bad++; $display("FAIL reset_ctl act=%h exp=0", {e2n, e2w, e3n, e3w, stall, st});
    end
    total++;
    if (dfb !== 32'h0) begin bad++; $display("FAIL reset_dfb act=%h exp=0", dfb); end
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_add();
    wwfpr = 1'b1; wrn = 5'd1; wmo = 32'h3F800000; tick();
    wrn = 5'd2; wmo = 32'h40000000; tick();
    wwfpr = 1'b0;
    fs = 5'd1; ft = 5'd2; fd = 5'd3; fc = 3'b000; wf = 1'b1;
    tick();
    wf = 1'b0;
    total++;
    if ({e1a, e1b} !== {32'h3F800000, 32'h40000000}) begin
      bad++; $display("FAIL add_e1ab act=%h exp=%h", {e1a, e1b}, {32'h3F800000, 32'h40000000});
    end
    total++;
    if ({e1n, e1w} !== {5'd3, 1'b1}) begin
      bad++; $display("FAIL add_e1nw act=%h exp=%h", {e1n, e1w}, {5'd3, 1'b1});
    end
    tick();
    total++;
    if ({e2n, e2w} !== {5'd3, 1'b1}) begin
      bad++; $display("FAIL add_e2 act=%h exp=%h", {e2n, e2w}, {5'd3, 1'b1});
    end
    tick();
    total++;
    if ({e3n, e3w} !== {5'd3, 1'b1}) begin
      bad++; $display("FAIL add_e3 act=%h exp=%h", {e3n, e3w}, {5'd3, 1'b1});
    end
    res = 32'h40400000; ft = 5'd3; #1;
    total++;
    if (e3d !== 32'h40400000) begin bad++; $display("FAIL add_e3d act=%h exp=40400000", e3d); end
    tick();
    res = '0;
    total++;
    if (dfb !== 32'h40400000) begin bad++; $display("FAIL add_wb_bypass act=%h exp=40400000", dfb); end
    tick();
    total++;
    if (dfb !== 32'h40400000) begin bad++; $display("FAIL add_fpr3 act=%h exp=40400000", dfb); end
  endtask

  task automatic test_forward();
    fwdfa = 1'b1; res = 32'h41200000; fwdlb = 1'b1; mmo = 32'hC0000000;
    fs = 5'd1; ft = 5'd2; fd = 5'd4; fc = 3'b000; wf = 1'b1;
    tick();
    total++;
    if ({e1a, e1b} !== {32'h41200000, 32'hC0000000}) begin
      bad++; $display("FAIL fwd_ab act=%h exp=%h", {e1a, e1b}, {32'h41200000, 32'hC0000000});
    end
    fwdla = 1'b1; res = 32'h01020304; mmo = 32'h0BADF00D;
    tick();
    total++;
    if ({e1a, e1b} !== {32'h01020304, 32'h0BADF00D}) begin
      bad++; $display("FAIL fwd_prio act=%h exp=%h", {e1a, e1b}, {32'h01020304, 32'h0BADF00D});
    end
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_div();
    fs = 5'd1; ft = 5'd2; fd = 5'd6; fc = 3'b011; wf = 1'b1;
    tick();
    // ID changes on purpose: a correct stall must keep the div in E1 anyway
    wf = 1'b0; fc = 3'b000;
    total++;
    if ({st, stall, e1c, e1n} !== {1'b1, 1'b1, 3'b011, 5'd6}) begin
      bad++; $display("FAIL div_start act=%h exp=%h", {st, stall, e1c, e1n}, {1'b1, 1'b1, 3'b011, 5'd6});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({st, stall, e2w, e1c} !== {1'b0, 1'b1, 1'b0, 3'b011}) begin
        bad++; $display("FAIL div_hold%0d act=%h exp=%h", k, {st, stall, e2w, e1c}, {1'b0, 1'b1, 1'b0, 3'b011});
      end
    end
    tick();
    total++;
    if ({stall, e2w, e1c, e1n, e1w} !== {1'b0, 1'b0, 3'b011, 5'd6, 1'b1}) begin
      bad++; $display("FAIL div_last act=%h exp=%h", {stall, e2w, e1c, e1n, e1w}, {1'b0, 1'b0, 3'b011, 5'd6, 1'b1});
    end
    tick();
    total++;
    if ({e2n, e2w, e1w} !== {5'd6, 1'b1, 1'b0}) begin
      bad++; $display("FAIL div_to_e2 act=%h exp=%h", {e2n, e2w, e1w}, {5'd6, 1'b1, 1'b0});
    end
    repeat (3) tick();
  endtask

  task automatic test_collision();
    fd = 5'd5; fc = 3'b000; wf = 1'b1; tick();
    wf = 1'b0; tick(); tick();
    res = 32'hDDDD0000; tick();
    res = '0;
    wwfpr = 1'b1; wrn = 5'd5; wmo = 32'hAAAA0000; ft = 5'd5; #1;
    total++;
    if (dfb !== 32'hAAAA0000) begin bad++; $display("FAIL coll_bypass act=%h exp=aaaa0000", dfb); end
    tick();
    wwfpr = 1'b0; #1;
    total++;
    if (dfb !== 32'hAAAA0000) begin bad++; $display("FAIL coll_fpr5 act=%h exp=aaaa0000", dfb); end
  endtask

  task automatic test_dfb_bypass();
    fd = 5'd9; fc = 3'b000; wf = 1'b1; tick();
    wf = 1'b0; tick(); tick();
    res = 32'h12345678; ft = 5'd9; tick();
    res = '0; #1;
    total++;
    if (dfb !== 32'h12345678) begin bad++; $display("FAIL dfb_bypass act=%h exp=12345678", dfb); end
    tick();
    total++;
    if (dfb !== 32'h12345678) begin bad++; $display("FAIL dfb_fpr9 act=%h exp=12345678", dfb); end
  endtask

  task automatic test_reset_mid_div();
    wwfpr = 1'b1; wrn = 5'd7; wmo = 32'hCAFEBABE; tick();
    wwfpr = 1'b0; ft = 5'd7; #1;
    total++;
    if (dfb !== 32'hCAFEBABE) begin bad++; $display("FAIL rst_pre_fpr7 act=%h exp=cafebabe", dfb); end
    fc = 3'b100; fd = 5'd8; wf = 1'b1; tick();
    wf = 1'b0; tick();
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall act=%b exp=1", stall); end
    #2 clrn = 1'b0;
    #1;
    m_reset();
    total++;
    if ({stall, st, e1w, e2w, e3w} !== 5'b0) begin
      bad++; $display("FAIL rst_mid_ctl act=%b exp=00000", {stall, st, e1w, e2w, e3w});
    end
    total++;
    if (dfb !== 32'h0) begin bad++; $display("FAIL rst_mid_dfb act=%h exp=0", dfb); end
    #1 clrn = 1'b1;
    set_idle();
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      fs    = 5'($urandom_range(0, 7));
      ft    = 5'($urandom_range(0, 7));
      fd    = 5'($urandom_range(0, 7));
      fc    = 3'($urandom_range(0, 7));
      wf    = ($urandom_range(0, 2) != 0);
      fwdfa = ($urandom_range(0, 3) == 0);
      fwdla = ($urandom_range(0, 3) == 0);
      fwdfb = ($urandom_range(0, 3) == 0);
      fwdlb = ($urandom_range(0, 3) == 0);
      mmo   = $urandom;
      wmo   = $urandom;
      res   = $urandom;
      wrn   = 5'($urandom_range(0, 7));
      wwfpr = ($urandom_range(0, 2) == 0);
      #1;
      total++;
      if ({e1a, e1b, e1c, e1n, e1w} !== {m_st[0].a, m_st[0].b, m_st[0].c, m_st[0].n, m_st[0].w}) begin
        bad++; $display("FAIL rnd_e1 it=%0d act=%h exp=%h", it, {e1a, e1b, e1c, e1n, e1w},
                        {m_st[0].a, m_st[0].b, m_st[0].c, m_st[0].n, m_st[0].w});
      end
      total++;
      if ({e2n, e2w, e3n, e3w} !== {m_st[1].n, m_st[1].w, m_st[2].n, m_st[2].w}) begin
        bad++; $display("FAIL rnd_e23 it=%0d act=%h exp=%h", it, {e2n, e2w, e3n, e3w},
                        {m_st[1].n, m_st[1].w, m_st[2].n, m_st[2].w});
      end
      total++;
      if ({stall, st} !== {(m_left > 1), m_start}) begin
        bad++; $display("FAIL rnd_stall it=%0d act=%b exp=%b", it, {stall, st}, {(m_left > 1), m_start});
      end
      total++;
      if (dfb !== mread(ft)) begin
        bad++; $display("FAIL rnd_dfb it=%0d act=%h exp=%h", it, dfb, mread(ft));
      end
      total++;
      if (e3d !== res) begin bad++; $display("FAIL rnd_e3d it=%0d act=%h exp=%h", it, e3d, res); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_div();
    test_collision();
    test_dfb_bypass();
    test_reset_mid_div();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
